// File: rtl/jtframe_rom_arb_if.sv
// Bus between ROM clients / framework and the SDRAM read arbiter.
// master = arbiter side, slave = clients + SDRAM controller side.
interface jtframe_rom_arb_if #(
    parameter int SLOTS = 4,
    parameter int AW    = 22
);
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_dout;
    logic                downloading;
    logic                loop_rst;
    logic                sdram_req;
    logic                sdram_ack;
    logic                data_rdy;
    logic [21:0]         sdram_addr;
    logic [31:0]         data_read;
    logic                refresh_en;

    modport master (
        input  slot_cs, slot_addr, downloading, loop_rst, sdram_ack, data_rdy, data_read,
        output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );
    modport slave (
        output slot_cs, slot_addr, downloading, loop_rst, sdram_ack, data_rdy, data_read,
        input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );
endinterface

// File: rtl/jtframe_rom_arb.sv
// N-slot SDRAM read arbiter with a one-entry cache per slot, fixed-priority
// or round-robin selection, per-slot 8/32-bit data width and word offsets.
module jtframe_rom_arb #(
    parameter int                  SLOTS     = 4,
    parameter int                  AW        = 22,
    parameter logic [SLOTS-1:0]    DW32_MASK = '0,
    parameter logic [SLOTS*22-1:0] OFFSETS   = '0,
    parameter int                  RR        = 0
)(
    input  logic               clk,
    input  logic               rst_n,
    jtframe_rom_arb_if.master  bus
);
    localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;

    logic [1:0]                 state;
    logic [SW-1:0]              sel, last_served, win;
    logic                       found;
    int                         idx;
    logic [AW-1:0]              req_addr;
    logic [21:0]                sdram_addr;
    logic                       sdram_req;
    logic [SLOTS-1:0]           valid, hit, pending;
    logic [SLOTS-1:0][AW-1:0]   addr, cache_addr;
    logic [SLOTS-1:0][31:0]     cache_data;
    logic [SLOTS-1:0][21:0]     word_addr;
    logic [31:0]                fill_data;

    assign addr          = bus.slot_addr;
    assign bus.slot_dout = cache_data;
    assign pending       = bus.slot_cs & ~hit;
    assign bus.slot_ok   = bus.slot_cs & hit;
    assign bus.sdram_req = sdram_req;
    assign bus.sdram_addr = sdram_addr;
    assign bus.refresh_en = bus.downloading | (state == IDLE && pending == '0);

    genvar i;
    generate
        for (i = 0; i < SLOTS; i++) begin : g_slot
            assign hit[i] = valid[i] && cache_addr[i] == addr[i];
            // 32-bit slots address words of two SDRAM half-words; 8-bit slots address bytes
            if (DW32_MASK[i]) begin : g_w32
                assign word_addr[i] = OFFSETS[i*22 +: 22] + 22'({addr[i], 1'b0});
            end else begin : g_w8
                assign word_addr[i] = OFFSETS[i*22 +: 22] + 22'(addr[i][AW-1:1]);
            end
        end
    endgenerate

    // round-robin starts after the last served slot; fixed priority starts at 0
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= SLOTS; k++) begin
            idx = (RR != 0) ? (int'(last_served) + k) % SLOTS : k - 1;
            if (!found && pending[idx]) begin
                win   = SW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        fill_data = bus.data_read;
        if (!DW32_MASK[sel])
            fill_data = {24'd0, req_addr[0] ? bus.data_read[15:8] : bus.data_read[7:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            sel         <= '0;
            last_served <= '0;
            req_addr    <= '0;
            valid       <= '0;
            cache_addr  <= '0;
            cache_data  <= '0;
        end else if (bus.downloading) begin
            state     <= IDLE;
            sdram_req <= 1'b0;
            valid     <= '0;
        end else begin
            // a fill landing in the same cycle as loop_rst keeps its entry
            if (bus.loop_rst) valid <= '0;
            case (state)
                IDLE: if (found) begin
                    sel        <= win;
                    sdram_addr <= word_addr[win];
                    req_addr   <= addr[win];
                    sdram_req  <= 1'b1;
                    state      <= REQ;
                end
                REQ: if (bus.sdram_ack) begin
                    sdram_req <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (bus.data_rdy) begin
                    valid[sel]      <= 1'b1;
                    cache_addr[sel] <= req_addr;
                    cache_data[sel] <= fill_data;
                    last_served     <= sel;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: an RR=0 instance behind an automatic SDRAM responder
// and an RR=1 instance driven by hand, checked against a transaction-level model.
module tb_jtframe_rom_arb;
    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam logic [SLOTS-1:0]    MASK = 4'b1000;
    localparam logic [SLOTS*22-1:0] OFFS = {22'h20000, 22'h30000, 22'h14000, 22'h00000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0, fails = 0;
    int cyc = 0;
    int ack_dly = 0, rdy_dly = 0;
    bit resp_busy = 0;
    int rdy_cyc = 0;
    logic [21:0] req_log[$];
    logic [31:0] ovr[int];
    int off[SLOTS] = '{0, 'h14000, 'h30000, 'h20000};
    logic [21:0] cur_a[SLOTS];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jtframe_rom_arb_if #(.SLOTS(SLOTS), .AW(AW)) bus0();
    jtframe_rom_arb_if #(.SLOTS(SLOTS), .AW(AW)) bus1();

    jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW32_MASK(MASK), .OFFSETS(OFFS), .RR(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW32_MASK(MASK), .OFFSETS(OFFS), .RR(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // ---------------- reference model ----------------
    function automatic bit is32(int s);
        return s == 3;
    endfunction

    function automatic logic [21:0] exp_sdram(int s, logic [21:0] a);
        longint t;
        if (is32(s)) t = longint'(off[s]) + 2 * longint'(a);
        else         t = longint'(off[s]) + longint'(a) / 2;
        return 22'(t % 4194304);
    endfunction

    function automatic logic [31:0] mem_word(logic [21:0] a);
        if (ovr.exists(int'(a))) return ovr[int'(a)];
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] exp_dout(int s, logic [21:0] a);
        logic [31:0] w;
        w = mem_word(exp_sdram(s, a));
        if (is32(s)) return w;
        return a[0] ? {24'd0, w[15:8]} : {24'd0, w[7:0]};
    endfunction

    function automatic logic [21:0] log_at(int i);
        if (i < req_log.size()) return req_log[i];
        return 'x;
    endfunction

    // ---------------- SDRAM responder for bus0 ----------------
    initial begin
        logic [21:0] a;
        bus0.sdram_ack = 1'b0; bus0.data_rdy = 1'b0; bus0.data_read = '0;
        forever begin
            @(posedge clk); #1;
            if (bus0.sdram_req) begin
                resp_busy = 1;
                a = bus0.sdram_addr;
                req_log.push_back(a);
                repeat (ack_dly) begin @(posedge clk); #1; end
                bus0.sdram_ack = 1'b1;
                @(posedge clk); #1;
                bus0.sdram_ack = 1'b0;
                repeat (rdy_dly) begin @(posedge clk); #1; end
                bus0.data_read = mem_word(a);
                bus0.data_rdy  = 1'b1;
                @(posedge clk); #1;
                rdy_cyc = cyc;
                bus0.data_rdy  = 1'b0;
                bus0.data_read = '0;
                resp_busy = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive0(int s, bit cs, logic [21:0] a);
        bus0.slot_cs[s] = cs;
        bus0.slot_addr[s*AW +: AW] = a;
        cur_a[s] = a;
    endtask

    task automatic drive1(int s, bit cs, logic [21:0] a);
        bus1.slot_cs[s] = cs;
        bus1.slot_addr[s*AW +: AW] = a;
    endtask

    function automatic logic [31:0] dout0(int s);
        return bus0.slot_dout[s*32 +: 32];
    endfunction

    task automatic wait_ok0(logic [SLOTS-1:0] m, output bit to, output int at);
        to = 1; at = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if ((bus0.slot_ok & m) == m) begin to = 0; at = cyc; break; end
        end
    endtask

    task automatic wait_idle0(output bit to);
        to = 1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (!resp_busy) begin to = 0; break; end
        end
    endtask

    // waits until bus0 has raised and then dropped sdram_req (ack taken, now in WAIT)
    task automatic wait_acked0(output bit to);
        bit seen;
        to = 1; seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus0.sdram_req) seen = 1;
            else if (seen) begin to = 0; break; end
        end
    endtask

    task automatic rr_serve(output logic [21:0] a, output bit to);
        to = 1; a = 'x;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (bus1.sdram_req) begin to = 0; break; end
        end
        if (!to) begin
            a = bus1.sdram_addr;
            bus1.sdram_ack = 1'b1;
            @(posedge clk); #1;
            bus1.sdram_ack = 1'b0;
            bus1.data_read = mem_word(a);
            bus1.data_rdy  = 1'b1;
            @(posedge clk); #1;
            bus1.data_rdy  = 1'b0;
        end
    endtask

    task automatic all_cs0_off();
        for (int s = 0; s < SLOTS; s++) drive0(s, 0, cur_a[s]);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus0.sdram_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", bus0.sdram_req); end
        tests++; if (bus0.sdram_addr !== 22'd0) begin fails++; $display("FAIL reset_addr got %h want 0", bus0.sdram_addr); end
        tests++; if (bus0.slot_ok !== 4'd0) begin fails++; $display("FAIL reset_ok got %b want 0", bus0.slot_ok); end
        tests++; if (bus0.slot_dout !== '0) begin fails++; $display("FAIL reset_dout got %h want 0", bus0.slot_dout); end
        tests++; if (bus0.refresh_en !== 1'b1) begin fails++; $display("FAIL reset_refresh got %b want 1", bus0.refresh_en); end
        tests++; if (bus1.sdram_req !== 1'b0 || bus1.refresh_en !== 1'b1) begin fails++; $display("FAIL reset_rr got req=%b ref=%b want 0/1", bus1.sdram_req, bus1.refresh_en); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic8();
        bit to; int at; int n;
        ack_dly = 0; rdy_dly = 2;
        ovr[int'(22'h14002)] = 32'h0000AB12;
        n = req_log.size();
        drive0(1, 1, 22'h5);
        wait_ok0(4'b0010, to, at);
        tests++; if (to) begin fails++; $display("FAIL b8_timeout got no ok want ok"); end
        tests++; if (log_at(n) !== 22'h14002) begin fails++; $display("FAIL b8_sdram_addr got %h want 14002", log_at(n)); end
        tests++; if (dout0(1) !== 32'h000000AB) begin fails++; $display("FAIL b8_dout got %h want ab", dout0(1)); end
        repeat (5) @(posedge clk); #1;
        tests++; if (req_log.size() != n + 1 || bus0.slot_ok[1] !== 1'b1) begin
            fails++; $display("FAIL b8_reread got reqs=%0d ok=%b want %0d/1", req_log.size(), bus0.slot_ok[1], n + 1); end
        drive0(1, 1, 22'h4);
        #1;
        tests++; if (bus0.slot_ok[1] !== 1'b0) begin fails++; $display("FAIL b8_addr_change_ok got %b want 0", bus0.slot_ok[1]); end
        drive0(1, 0, 22'h5);
    endtask

    task automatic test_32();
        bit to; int at; int n;
        ack_dly = 1; rdy_dly = 3;
        ovr[int'(22'h20020)] = 32'hDEADBEEF;
        n = req_log.size();
        drive0(3, 1, 22'h10);
        wait_ok0(4'b1000, to, at);
        @(posedge clk); #1;
        tests++; if (to) begin fails++; $display("FAIL w32_timeout got no ok want ok"); end
        tests++; if (log_at(n) !== 22'h20020) begin fails++; $display("FAIL w32_sdram_addr got %h want 20020", log_at(n)); end
        tests++; if (dout0(3) !== 32'hDEADBEEF) begin fails++; $display("FAIL w32_dout got %h want deadbeef", dout0(3)); end
        tests++; if (at != rdy_cyc) begin fails++; $display("FAIL w32_latency got ok at %0d want %0d", at, rdy_cyc); end
        tests++; if (bus0.refresh_en !== 1'b1) begin fails++; $display("FAIL w32_refresh got %b want 1", bus0.refresh_en); end
        all_cs0_off();
    endtask

    task automatic test_fixed_prio();
        bit to; int at; int n;
        logic [21:0] a0, a2, a3;
        ack_dly = 0; rdy_dly = 1;
        a0 = 22'h100 + 22'($urandom_range(0, 255));
        a2 = 22'h100 + 22'($urandom_range(0, 255));
        a3 = 22'h100 + 22'($urandom_range(0, 255));
        n = req_log.size();
        drive0(0, 1, a0); drive0(2, 1, a2); drive0(3, 1, a3);
        wait_ok0(4'b1101, to, at);
        tests++; if (to) begin fails++; $display("FAIL prio_timeout got ok=%b want 1101", bus0.slot_ok); end
        tests++; if (req_log.size() != n + 3 || log_at(n) !== exp_sdram(0, a0) || log_at(n+1) !== exp_sdram(2, a2) || log_at(n+2) !== exp_sdram(3, a3)) begin
            fails++; $display("FAIL prio_order got %h %h %h want %h %h %h", log_at(n), log_at(n+1), log_at(n+2),
                              exp_sdram(0, a0), exp_sdram(2, a2), exp_sdram(3, a3)); end
        tests++; if (dout0(0) !== exp_dout(0, a0) || dout0(2) !== exp_dout(2, a2) || dout0(3) !== exp_dout(3, a3)) begin
            fails++; $display("FAIL prio_dout got %h %h %h want %h %h %h", dout0(0), dout0(2), dout0(3),
                              exp_dout(0, a0), exp_dout(2, a2), exp_dout(3, a3)); end
        all_cs0_off();
    endtask

    task automatic test_rr();
        logic [21:0] a, ga, gb;
        bit to, tb2;
        logic [21:0] ad[SLOTS];
        ad[0] = 22'h22; ad[1] = 22'h11; ad[2] = 22'h40; ad[3] = 22'h33;
        drive1(2, 1, ad[2]);
        rr_serve(a, to);
        tests++; if (to || a !== exp_sdram(2, ad[2])) begin fails++; $display("FAIL rr_first got %h want %h", a, exp_sdram(2, ad[2])); end
        drive1(0, 1, ad[0]); drive1(3, 1, ad[3]);
        rr_serve(ga, to);
        rr_serve(gb, tb2);
        tests++; if (to || tb2 || ga !== exp_sdram(3, ad[3]) || gb !== exp_sdram(0, ad[0])) begin
            fails++; $display("FAIL rr_order got %h %h want %h %h", ga, gb, exp_sdram(3, ad[3]), exp_sdram(0, ad[0])); end
        drive1(1, 1, ad[1]);
        bus1.loop_rst = 1'b1;
        @(posedge clk); #1;
        bus1.loop_rst = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            rr_serve(a, to);
            tests++; if (to || a !== exp_sdram((k + 1) % SLOTS, ad[(k + 1) % SLOTS])) begin
                fails++; $display("FAIL rr_wrap_%0d got %h want %h", k, a, exp_sdram((k + 1) % SLOTS, ad[(k + 1) % SLOTS])); end
        end
        tests++; if (bus1.slot_ok !== 4'b1111 || bus1.slot_dout[31:0] !== exp_dout(0, ad[0])) begin
            fails++; $display("FAIL rr_ok got ok=%b d0=%h want 1111/%h", bus1.slot_ok, bus1.slot_dout[31:0], exp_dout(0, ad[0])); end
        bus1.slot_cs = '0;
    endtask

    task automatic test_ack_hold();
        bit to; int at; int bad;
        logic [21:0] held;
        ack_dly = 10; rdy_dly = 1;
        drive0(0, 1, 22'h200);
        @(posedge clk); #1;
        held = bus0.sdram_addr;
        tests++; if (bus0.sdram_req !== 1'b1 || held !== exp_sdram(0, 22'h200)) begin
            fails++; $display("FAIL hold_start got req=%b addr=%h want 1/%h", bus0.sdram_req, held, exp_sdram(0, 22'h200)); end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus0.sdram_req !== 1'b1 || bus0.sdram_addr !== held || bus0.refresh_en !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
        wait_ok0(4'b0001, to, at);
        tests++; if (to || dout0(0) !== exp_dout(0, 22'h200)) begin fails++; $display("FAIL hold_dout got %h want %h", dout0(0), exp_dout(0, 22'h200)); end
        all_cs0_off();
    endtask

    task automatic test_addr_change();
        bit to; int at; int n; int bad;
        ack_dly = 0; rdy_dly = 5;
        n = req_log.size();
        drive0(2, 1, 22'h300);
        wait_acked0(to);
        tests++; if (to) begin fails++; $display("FAIL chg_ack_timeout got no ack want ack"); end
        drive0(2, 1, 22'h302);
        bad = 0;
        for (int k = 0; k < 100 && req_log.size() < n + 2; k++) begin
            @(posedge clk); #1;
            if (req_log.size() < n + 2 && bus0.slot_ok[2] !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL chg_ok_low got %0d early ok cycles want 0", bad); end
        wait_ok0(4'b0100, to, at);
        tests++; if (to || log_at(n) !== exp_sdram(2, 22'h300) || log_at(n+1) !== exp_sdram(2, 22'h302)) begin
            fails++; $display("FAIL chg_reqs got %h %h want %h %h", log_at(n), log_at(n+1), exp_sdram(2, 22'h300), exp_sdram(2, 22'h302)); end
        tests++; if (dout0(2) !== exp_dout(2, 22'h302)) begin fails++; $display("FAIL chg_dout got %h want %h", dout0(2), exp_dout(2, 22'h302)); end
    endtask

    task automatic test_download();
        bit to; int at; int n; int bad;
        ack_dly = 0; rdy_dly = 4;
        for (int s = 0; s < SLOTS; s++) drive0(s, 1, (s == 1) ? 22'h7 : cur_a[s]);
        wait_acked0(to);
        bus0.downloading = 1'b1;
        n = req_log.size();
        @(posedge clk); #1;
        tests++; if (to || bus0.sdram_req !== 1'b0 || bus0.slot_ok !== 4'b0 || bus0.refresh_en !== 1'b1) begin
            fails++; $display("FAIL dl_entry got req=%b ok=%b ref=%b want 0/0000/1", bus0.sdram_req, bus0.slot_ok, bus0.refresh_en); end
        bad = 0;
        for (int k = 0; k < 30 && (resp_busy || k < 3); k++) begin
            @(posedge clk); #1;
            if (bus0.sdram_req !== 1'b0) bad++;
        end
        tests++; if (bad != 0 || resp_busy) begin fails++; $display("FAIL dl_no_req got %0d req cycles busy=%b want 0/0", bad, resp_busy); end
        bus0.downloading = 1'b0;
        #1;
        tests++; if (bus0.slot_ok !== 4'b0) begin fails++; $display("FAIL dl_valid got ok=%b want 0000", bus0.slot_ok); end
        wait_ok0(4'b1111, to, at);
        tests++; if (to || req_log.size() != n + 4 || log_at(n) !== exp_sdram(0, cur_a[0]) || log_at(n+1) !== exp_sdram(1, 22'h7)
                     || log_at(n+3) !== exp_sdram(3, cur_a[3])) begin
            fails++; $display("FAIL dl_refill got n=%0d first=%h want %0d/%h", req_log.size() - n, log_at(n), 4, exp_sdram(0, cur_a[0])); end
        tests++; if (dout0(1) !== exp_dout(1, 22'h7)) begin fails++; $display("FAIL dl_dout got %h want %h", dout0(1), exp_dout(1, 22'h7)); end
        all_cs0_off();
    endtask

    task automatic test_reset_mid();
        bit to; int at;
        ack_dly = 8; rdy_dly = 1;
        drive0(2, 1, 22'h500);
        @(posedge clk); #1;
        tests++; if (bus0.sdram_req !== 1'b1) begin fails++; $display("FAIL rmid_req got %b want 1", bus0.sdram_req); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        all_cs0_off();
        @(posedge clk); #1;
        tests++; if (bus0.sdram_req !== 1'b0 || bus0.sdram_addr !== 22'd0 || bus0.slot_ok !== 4'b0
                     || bus0.slot_dout !== '0 || bus0.refresh_en !== 1'b1) begin
            fails++; $display("FAIL rmid_outputs got req=%b addr=%h ok=%b ref=%b want 0/0/0/1",
                              bus0.sdram_req, bus0.sdram_addr, bus0.slot_ok, bus0.refresh_en); end
        wait_idle0(to);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive0(2, 1, 22'h500);
        #1;
        tests++; if (to || bus0.slot_ok[2] !== 1'b0) begin fails++; $display("FAIL rmid_stale got ok=%b want 0", bus0.slot_ok[2]); end
        ack_dly = 0;
        wait_ok0(4'b0100, to, at);
        tests++; if (to || dout0(2) !== exp_dout(2, 22'h500)) begin fails++; $display("FAIL rmid_refill got %h want %h", dout0(2), exp_dout(2, 22'h500)); end
        all_cs0_off();
    endtask

    task automatic test_loop_rst();
        bit to; int at; int n; int bad;
        ack_dly = 1; rdy_dly = 0;
        for (int s = 0; s < SLOTS; s++) drive0(s, 1, 22'($urandom_range(0, 'h3FFFFF)));
        wait_ok0(4'b1111, to, at);
        tests++; if (to) begin fails++; $display("FAIL lrst_fill got ok=%b want 1111", bus0.slot_ok); end
        n = req_log.size();
        bus0.loop_rst = 1'b1;
        @(posedge clk); #1;
        bus0.loop_rst = 1'b0;
        tests++; if (bus0.slot_ok !== 4'b0) begin fails++; $display("FAIL lrst_ok got %b want 0000", bus0.slot_ok); end
        wait_ok0(4'b1111, to, at);
        bad = 0;
        for (int s = 0; s < SLOTS; s++) if (log_at(n + s) !== exp_sdram(s, cur_a[s]) || dout0(s) !== exp_dout(s, cur_a[s])) bad++;
        tests++; if (to || bad != 0) begin fails++; $display("FAIL lrst_order got %0d bad slots want 0", bad); end
        all_cs0_off();
    endtask

    task automatic test_random();
        bit to; int at; int n; int bad;
        logic [SLOTS-1:0] m;
        logic [21:0] prev[SLOTS];
        logic [21:0] a;
        @(posedge clk); #1;
        bus0.loop_rst = 1'b1;
        @(posedge clk); #1;
        bus0.loop_rst = 1'b0;
        for (int s = 0; s < SLOTS; s++) prev[s] = '1;
        // 32-bit address wraps the 22-bit SDRAM space
        n = req_log.size();
        drive0(3, 1, 22'h3FFFF0);
        prev[3] = 22'h3FFFF0;
        wait_ok0(4'b1000, to, at);
        tests++; if (to || log_at(n) !== 22'h01FFE0) begin fails++; $display("FAIL rnd_wrap got %h want 01ffe0", log_at(n)); end
        all_cs0_off();
        for (int it = 0; it < 16; it++) begin
            ack_dly = $urandom_range(0, 3);
            rdy_dly = $urandom_range(0, 3);
            m = 4'($urandom_range(1, 15));
            n = req_log.size();
            for (int s = 0; s < SLOTS; s++) begin
                if (m[s]) begin
                    a = 22'($urandom_range(0, 'h3FFFFF));
                    if (a == prev[s]) a = a ^ 22'h2;
                    prev[s] = a;
                    drive0(s, 1, a);
                end
            end
            wait_ok0(m, to, at);
            bad = 0;
            for (int s = 0, j = 0; s < SLOTS; s++) begin
                if (m[s]) begin
                    if (log_at(n + j) !== exp_sdram(s, cur_a[s]) || dout0(s) !== exp_dout(s, cur_a[s])) bad++;
                    j++;
                end
            end
            tests++; if (to || bad != 0 || req_log.size() != n + $countones(m)) begin
                fails++; $display("FAIL rnd_%0d got %0d bad slots mask=%b reqs=%0d want 0/%0d", it, bad, m, req_log.size() - n, $countones(m)); end
            all_cs0_off();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus0.slot_cs = '0; bus0.slot_addr = '0; bus0.downloading = 1'b0; bus0.loop_rst = 1'b0;
        bus1.slot_cs = '0; bus1.slot_addr = '0; bus1.downloading = 1'b0; bus1.loop_rst = 1'b0;
        bus1.sdram_ack = 1'b0; bus1.data_rdy = 1'b0; bus1.data_read = '0;
        for (int s = 0; s < SLOTS; s++) cur_a[s] = '0;
        test_reset();
        test_basic8();
        test_32();
        test_fixed_prio();
        test_rr();
        test_ack_hold();
        test_addr_change();
        test_download();
        test_reset_mid();
        test_loop_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jtframe_rom_arb.md
Name: jtframe_rom_arb

Overview:
- Parametrised N-slot SDRAM read arbiter and per-slot one-entry cache; successor to the fixed nine-slot ROM multiplexer used by game tops.
- Sits between the game's ROM clients (CPUs, MCU, sound, GFX) and the framework SDRAM controller.
- Adds configurable slot count, per-slot 8/32-bit data width, packed offsets and a selectable fixed-priority or round-robin arbitration mode.

Parameters:
- SLOTS, 4, number of client slots (1..8).
- AW, 22, address width of every slot's byte/word address field.
- DW32_MASK, 0, bit i=1 means slot i is 32-bit (address counts 32-bit words); 0 means 8-bit (address counts bytes).
- OFFSETS, 0, packed SLOTS*22 bits; slot i SDRAM 16-bit-word offset in bits [22i+21:22i].
- RR, 0, 0 = fixed priority (slot 0 highest); 1 = round-robin.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- slot_cs  in  SLOTS  per-slot read request.
- slot_addr  in  SLOTS*AW  packed per-slot address.
- slot_ok  out  SLOTS  slot_dout valid for current slot_addr.
- slot_dout  out  SLOTS*32  packed data; 8-bit slots use bits [7:0], upper bits zero.
- downloading  in  1  ROM load in progress.
- loop_rst  in  1  invalidate all caches.
- sdram_req  out  1  read request.
- sdram_ack  in  1  controller accepted request.
- data_rdy  in  1  data_read valid.
- sdram_addr  out  22  16-bit-word SDRAM address.
- data_read  in  32  SDRAM read data.
- refresh_en  out  1  high when no request is pending or in flight.

Behaviour:
- Reset (rst_n low at a clk edge):
  - outputs after reset: sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, refresh_en=1.
  - all cache valid bits cleared; FSM goes to IDLE; round-robin pointer = 0.
  - applies mid-transfer as well; a data_rdy arriving after reset is ignored.
- Per-slot cache: cached address, 32-bit data, valid bit.
  - hit_i = valid_i & (cached_addr_i == slot_addr_i).
  - slot_ok_i = slot_cs_i & hit_i, combinational from the registered cache. It drops in the same cycle the address changes.
- Pending set: slot_cs_i & ~hit_i.
- SDRAM address:
  - 8-bit slot: OFFSET_i + slot_addr_i[AW-1:1].
  - 32-bit slot: OFFSET_i + {slot_addr_i,1'b0}.
  - 22-bit unsigned sum; overflow wraps.
- FSM states:
  - IDLE: if any slot is pending and downloading=0, choose the winner, register sel, sdram_addr and the request address, and set sdram_req=1 on the next edge → REQ. Otherwise stay in IDLE with refresh_en=1.
  - REQ: hold sdram_req and sdram_addr stable until sdram_ack=1. On the ack edge sdram_req←0 → WAIT. The request is never withdrawn, even if slot_cs drops.
  - WAIT: on data_rdy, store the cache entry for sel and set its valid bit → IDLE.
    - 32-bit slot: cache data = data_read.
    - 8-bit slot: cache data = {24'd0, captured addr[0] ? data_read[15:8] : data_read[7:0]}.
    - cached address = captured request address, not the live slot_addr.
- Latency: a cs/address change in cycle 0 gives sdram_req high at edge 1. slot_ok rises the cycle after the data_rdy edge. Minimum miss-to-ok = 3 + ack wait + data wait cycles.
- refresh_en = 1 only in IDLE with no pending slot, or while downloading=1.
- Arbitration:
  - RR=0: lowest pending index wins.
  - RR=1: search starts at (last_served+1) mod SLOTS; pointer updates on each WAIT completion.
- Simultaneous events:
  - The IDLE decision uses only the pending set. A slot that becomes a hit in the same cycle it is served does not re-request.
  - If slot_addr changes during REQ/WAIT, the fill still completes with the old address; ok stays low and a new request follows.
- downloading=1: FSM forced to IDLE next edge, sdram_req←0, all valid cleared, data_rdy ignored. No requests are issued while it stays high.
- loop_rst=1: clears all valid bits only; any in-flight transfer completes normally.

Test Plan:
- Reset then SLOTS=4, OFFSETS slot1=0x14000, slot1 8-bit cs with addr 0x0005 → sdram_addr=0x14002; data_read=0x0000_AB12 → slot1 dout=0xAB; re-read of addr 0x0005 gives ok with no new sdram_req.
- 32-bit slot 3 (offset 0x20000), addr 0x10 → sdram_addr=0x20020; dout=data_read=0xDEADBEEF; ok one cycle after data_rdy.
- RR=0, slots 0, 2 and 3 pending together → service order 0, 2, 3. RR=1 with last_served=2 and slots 0 and 3 pending → 3 then 0.
- Hold sdram_ack low for 10 cycles → sdram_req and sdram_addr stable throughout, refresh_en=0. Change slot addr during WAIT → stored entry uses the old address, ok stays 0, second request issued.
- Assert downloading during WAIT → req=0 next cycle, ok all 0, the following data_rdy does not set valid. rst_n low during REQ → all outputs at reset values next edge.
- All slots hitting, then loop_rst pulse → slot_ok all 0 next cycle and fresh requests issued in priority order.
